// File: rtl/booth_seq_mult_if.sv
// rtl/booth_seq_mult_if.sv - start/busy/done handshake and operand/product bus for booth_seq_mult
interface booth_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic               start;
    logic [WIDTH-1:0]   M;
    logic [WIDTH-1:0]   Q;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] Z;

    modport master (
        output start, M, Q,
        input  busy, done, Z
    );

    modport slave (
        input  start, M, Q,
        output busy, done, Z
    );
endinterface

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-2 Booth multiplier, one add/sub-and-shift step per clock
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_seq_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH:0]       acc;
    logic [WIDTH-1:0]     mq;
    logic                 q_1;
    logic [WIDTH:0]       mcand;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   z_r;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       acc_next;
    logic [WIDTH-1:0]     mq_next;
    logic                 q1_next;
    logic                 load;
    logic                 last;

    // Operands are taken only when no operation is in flight; start during CALC is dropped.
    assign load = bus.start && (state != CALC);
    assign last = (state == CALC) && (cnt == CW'(1));

    always_comb begin
        sum = acc;
        case ({mq[0], q_1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        mq_next  = {sum[0], mq[WIDTH-1:1]};
        q1_next  = mq[0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = bus.start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mq    <= '0;
            q_1   <= 1'b0;
            mcand <= '0;
            cnt   <= '0;
            z_r   <= '0;
        end else if (load) begin
            acc   <= '0;
            mq    <= bus.Q;
            q_1   <= 1'b0;
            mcand <= {bus.M[WIDTH-1], bus.M};
            cnt   <= CW'(WIDTH);
        end else if (state == CALC) begin
            acc <= acc_next;
            mq  <= mq_next;
            q_1 <= q1_next;
            cnt <= cnt - CW'(1);
            if (last) begin
                z_r <= {acc_next[WIDTH-1:0], mq_next};
            end
        end
    end

    assign bus.busy = (state == CALC);
    assign bus.done = (state == DONE);
    assign bus.Z    = z_r;
endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - self-checking bench for booth_seq_mult against a signed-multiply model
module tb_booth_seq_mult;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    booth_seq_mult_if #(.WIDTH(W)) bus ();

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[2*W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete multiply from IDLE; inj>0 pulses a stray start with junk operands at edge t_inj.
    task automatic run_mult(input logic [W-1:0] m, input logic [W-1:0] q, input int inj);
        logic [2*W-1:0] exp;
        exp = model(m, q);
        bus.M = m;
        bus.Q = q;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_t0", {31'b0, bus.busy}, 32'd1);
        for (int k = 1; k <= W; k++) begin
            if (k == inj) begin
                bus.start = 1'b1;
                bus.M = W'($urandom);
                bus.Q = W'($urandom);
            end
            step();
            if (k == inj) bus.start = 1'b0;
            if (k < W) begin
                check("busy_calc", {31'b0, bus.busy}, 32'd1);
                check("done_calc", {31'b0, bus.done}, 32'd0);
            end else begin
                check("done_pulse", {31'b0, bus.done}, 32'd1);
                check("busy_done", {31'b0, bus.busy}, 32'd0);
                check("z_result", {16'b0, bus.Z}, {16'b0, exp});
            end
        end
        step();
        check("done_drop", {31'b0, bus.done}, 32'd0);
        check("busy_idle", {31'b0, bus.busy}, 32'd0);
        check("z_hold", {16'b0, bus.Z}, {16'b0, exp});
    endtask

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] q;
    } pair_t;

    pair_t dir[$];
    pair_t b2b[$];

    initial begin
        checks = 0;
        failures = 0;
        bus.start = 1'b0;
        bus.M = '0;
        bus.Q = '0;
        rst_n = 1'b0;
        #17;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_z", {16'b0, bus.Z}, 32'd0);
        rst_n = 1'b1;
        step();

        run_mult(8'd4, 8'd2, 0);
        check("z_4x2", {16'b0, bus.Z}, 32'h0008);

        dir.push_back('{8'hCE, 8'd50});
        dir.push_back('{8'd30, 8'hC4});
        dir.push_back('{8'hFB, 8'd2});
        dir.push_back('{8'h80, 8'h80});
        dir.push_back('{8'h80, 8'd1});
        dir.push_back('{8'd0, 8'hFF});
        dir.push_back('{8'h7F, 8'h80});
        dir.push_back('{8'h7F, 8'h7F});
        foreach (dir[i]) run_mult(dir[i].m, dir[i].q, 0);
        run_mult(8'h80, 8'h80, 0);
        check("z_min_sq", {16'b0, bus.Z}, 32'h4000);

        for (int i = 0; i < 24; i++) run_mult(W'($urandom), W'($urandom), 0);

        run_mult(8'hCE, 8'd50, 3);
        check("z_ignore_start", {16'b0, bus.Z}, 32'hF63C);

        // Start held high; the next operands are presented during each done cycle.
        for (int i = 0; i < 5; i++) b2b.push_back('{W'($urandom), W'($urandom)});
        bus.M = b2b[0].m;
        bus.Q = b2b[0].q;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("b2b_busy_t0", {31'b0, bus.busy}, 32'd1);
            check("b2b_done_t0", {31'b0, bus.done}, 32'd0);
            for (int k = 1; k <= W; k++) begin
                step();
                if (k < W) begin
                    check("b2b_busy", {31'b0, bus.busy}, 32'd1);
                end else begin
                    check("b2b_done", {31'b0, bus.done}, 32'd1);
                    check("b2b_z", {16'b0, bus.Z}, {16'b0, model(b2b[i].m, b2b[i].q)});
                end
            end
            if (i < 4) begin
                bus.M = b2b[i+1].m;
                bus.Q = b2b[i+1].q;
            end else begin
                bus.start = 1'b0;
            end
        end
        step();
        check("b2b_end_idle", {31'b0, bus.busy}, 32'd0);

        // Asynchronous abort in the middle of CALC.
        bus.M = 8'd100;
        bus.Q = 8'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_z", {16'b0, bus.Z}, 32'd0);
        step();
        check("abort_hold_busy", {31'b0, bus.busy}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        run_mult(8'd7, 8'hFD, 0);
        check("z_after_abort", {16'b0, bus.Z}, 32'hFFEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
